// File: rtl/accum_seq_ctrl.sv
// Sequencer for the 16-bit ripple-adder accumulator lab: drives the result register's load
// strobe and input mux for single loads and repeated-add runs started by debounced buttons.
module accum_seq_ctrl #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic             Run,
  input  logic [CNT_W-1:0] Reps,
  input  logic             Add_Ofl,
  output logic             Ld_B,
  output logic             Sel_Sum,
  output logic             Busy,
  output logic             Done,
  output logic             Ofl_Sticky,
  output logic [CNT_W-1:0] Iter
);

  typedef enum logic [2:0] {StIdle, StLoad, StAdd, StDone, StWaitRel} state_e;

  state_e           state_q, state_d;
  logic             load_q, run_q;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             ofl_q, ofl_d;
  logic             load_edge, run_edge;

  assign load_edge = Load & ~load_q;
  assign run_edge  = Run & ~run_q;

  // History resets high so a button already held through reset needs a fresh press.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      load_q  <= 1'b1;
      run_q   <= 1'b1;
      rem_q   <= '0;
      iter_q  <= '0;
      ofl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= Load;
      run_q   <= Run;
      rem_q   <= rem_d;
      iter_q  <= iter_d;
      ofl_q   <= ofl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    iter_d  = iter_q;
    ofl_d   = ofl_q;
    unique case (state_q)
      StIdle: begin
        if (load_edge) begin
          state_d = StLoad;
        end else if (run_edge) begin
          iter_d = '0;
          ofl_d  = 1'b0;
          if (Reps == '0) begin
            state_d = StDone;
          end else begin
            state_d = StAdd;
            rem_d   = Reps;
          end
        end
      end
      StLoad: begin
        iter_d  = '0;
        ofl_d   = 1'b0;
        state_d = StDone;
      end
      StAdd: begin
        ofl_d  = ofl_q | Add_Ofl;
        iter_d = iter_q + CNT_W'(1);
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = StDone;
      end
      StDone: state_d = StWaitRel;
      StWaitRel: begin
        if (!Load && !Run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode only the state register, so they hold steady for the whole cycle.
  always_comb begin
    Ld_B    = 1'b0;
    Sel_Sum = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state_q)
      StLoad: begin
        Ld_B = 1'b1;
        Busy = 1'b1;
      end
      StAdd: begin
        Ld_B    = 1'b1;
        Sel_Sum = 1'b1;
        Busy    = 1'b1;
      end
      StDone: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  assign Ofl_Sticky = ofl_q;
  assign Iter       = iter_q;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl: cycle-by-cycle vector table plus hand-written reset abort.
module tb_accum_seq_ctrl;
  localparam int unsigned CNT_W = 4;

  logic             Clk = 1'b0;
  logic             Reset, Load, Run, Add_Ofl;
  logic [CNT_W-1:0] Reps;
  logic             Ld_B, Sel_Sum, Busy, Done, Ofl_Sticky;
  logic [CNT_W-1:0] Iter;

  int n_checks = 0;
  int n_fail   = 0;

  // exp packs {Ld_B, Sel_Sum, Busy, Done, Ofl_Sticky, Iter}
  typedef struct {
    logic       load;
    logic       run;
    logic [3:0] reps;
    logic       ofl;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[32];

  always #5 Clk = ~Clk;

  accum_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Run       (Run),
    .Reps      (Reps),
    .Add_Ofl   (Add_Ofl),
    .Ld_B      (Ld_B),
    .Sel_Sum   (Sel_Sum),
    .Busy      (Busy),
    .Done      (Done),
    .Ofl_Sticky(Ofl_Sticky),
    .Iter      (Iter)
  );

  function automatic vec_t mk(bit l, bit r, int reps, bit ao, bit ld, bit sel, bit busy,
                              bit done, bit ofs, int iter);
    vec_t v;
    v.load = l;
    v.run  = r;
    v.reps = 4'(reps);
    v.ofl  = ao;
    v.exp  = {ld, sel, busy, done, ofs, 4'(iter)};
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {Ld_B, Sel_Sum, Busy, Done, Ofl_Sticky, Iter};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    int pulses;
    bit done_seen;

    //               L  R  reps ao  ld sel busy done ofs iter
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);  // load press
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  // held: no retrigger
    vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 3, 0, 1, 1, 1, 0, 0, 0);  // run, reps 3
    vecs[8]  = mk(0, 0, 7, 0, 1, 1, 1, 0, 0, 1);  // reps change ignored
    vecs[9]  = mk(1, 0, 7, 0, 1, 1, 1, 0, 0, 2);  // load edge during ADD dropped
    vecs[10] = mk(0, 0, 7, 0, 0, 0, 1, 1, 0, 3);
    vecs[11] = mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 3);
    vecs[12] = mk(0, 0, 7, 0, 0, 0, 0, 0, 0, 3);
    vecs[13] = mk(0, 1, 5, 0, 1, 1, 1, 0, 0, 0);  // run, reps 5
    vecs[14] = mk(0, 0, 5, 0, 1, 1, 1, 0, 0, 1);
    vecs[15] = mk(0, 0, 5, 1, 1, 1, 1, 0, 1, 2);  // overflow in 2nd ADD
    vecs[16] = mk(0, 0, 5, 0, 1, 1, 1, 0, 1, 3);
    vecs[17] = mk(0, 0, 5, 0, 1, 1, 1, 0, 1, 4);
    vecs[18] = mk(0, 0, 5, 0, 0, 0, 1, 1, 1, 5);
    vecs[19] = mk(0, 0, 5, 0, 0, 0, 0, 0, 1, 5);
    vecs[20] = mk(0, 0, 5, 0, 0, 0, 0, 0, 1, 5);
    vecs[21] = mk(1, 0, 5, 0, 1, 0, 1, 0, 1, 5);  // load clears sticky/iter
    vecs[22] = mk(0, 0, 5, 0, 0, 0, 1, 1, 0, 0);
    vecs[23] = mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    vecs[24] = mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
    vecs[25] = mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);  // reps 0
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[28] = mk(1, 1, 3, 0, 1, 0, 1, 0, 0, 0);  // simultaneous edges
    vecs[29] = mk(1, 1, 3, 0, 0, 0, 1, 1, 0, 0);
    vecs[30] = mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    vecs[31] = mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0);

    Reset   = 1'b1;
    Load    = 1'b1;
    Run     = 1'b0;
    Reps    = '0;
    Add_Ofl = 1'b0;
    repeat (2) tick();
    check("reset_outputs", 32'(outs()), 32'h0);
    Reset = 1'b0;
    tick();
    tick();
    check("load_held_through_reset", 32'(outs()), 32'h0);

    for (int i = 0; i < 32; i++) begin
      Load    = vecs[i].load;
      Run     = vecs[i].run;
      Reps    = vecs[i].reps;
      Add_Ofl = vecs[i].ofl;
      tick();
      check($sformatf("row%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Reset abort in the middle of an 8-add run with Run held.
    Load = 1'b0;
    Reps = 4'd8;
    Run  = 1'b1;
    tick();
    check("abort_ld1", 32'({Ld_B, Sel_Sum}), 32'b11);
    tick();
    check("abort_ld2", 32'(Ld_B), 32'd1);
    tick();
    check("abort_ld3_iter", 32'({Ld_B, Iter}), 32'h12);
    Reset = 1'b1;
    #1;
    check("abort_immediate", 32'(outs()), 32'h0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("abort_held_idle%0d", c), 32'({Ld_B, Busy}), 32'h0);
    end
    Run = 1'b0;
    tick();
    Run = 1'b1;
    tick();
    check("rerun_first_ld", 32'({Ld_B, Iter}), 32'h10);
    Run       = 1'b0;
    pulses    = 1;
    done_seen = 1'b0;
    for (int c = 0; c < 30 && !done_seen; c++) begin
      tick();
      if (Ld_B) pulses++;
      if (Done) done_seen = 1'b1;
    end
    check("rerun_done_seen", 32'(done_seen), 32'd1);
    check("rerun_pulses", 32'(pulses), 32'd8);
    check("rerun_iter", 32'(Iter), 32'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_seq_ctrl.md
Name: accum_seq_ctrl

Overview:
- Control unit for the 16-bit ripple-adder lab datapath.
- Sequences the result register (16-bit data plus overflow bit, load-strobed) and its input mux.
- Two operations:
  - Load: copies the switch value into the result register.
  - Run: repeatedly adds the switch operand into the register Reps times, with a sticky overflow flag.
- Sits between the debounced push-buttons and the adder/register datapath.

Parameters:
- CNT_W, 4, width of the repetition count and the iteration counter (max Reps = 2^CNT_W-1).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  reset Reset, asynchronous, active-high.
- Load  input  1  level button (debounced); a rising edge requests a load.
- Run  input  1  level button (debounced); a rising edge requests an accumulate run.
- Reps  input  CNT_W  number of additions; sampled only on an accepted Run edge.
- Add_Ofl  input  1  signed overflow of the current adder output (combinational from datapath).
- Ld_B  output  1  one-cycle load strobe to the result register.
- Sel_Sum  output  1  register input mux: 0 = switches, 1 = adder sum.
- Busy  output  1  high in LOAD, ADD, DONE.
- Done  output  1  one-cycle completion pulse.
- Ofl_Sticky  output  1  OR of Add_Ofl over every ADD cycle of the current run.
- Iter  output  CNT_W  additions completed in the current/last run.

Behaviour:
- Reset values:
  - State = IDLE.
  - Ld_B, Sel_Sum, Busy, Done = 0; Ofl_Sticky = 0; Iter = 0; remaining counter = 0.
  - Button history registers = 1, so buttons held through reset do not trigger.
- Edge detect:
  - Load_edge = Load & ~Load_q; Run_edge = Run & ~Run_q.
  - Load_q and Run_q are updated every cycle.
- IDLE:
  - Load_edge (has priority if both edges occur in the same cycle) -> LOAD.
  - Else Run_edge with Reps=0 -> DONE; Iter=0, Ofl_Sticky=0, no register write.
  - Else Run_edge with Reps>0 -> ADD; rem<=Reps, Iter<=0, Ofl_Sticky<=0.
  - Otherwise stay in IDLE.
- LOAD, exactly 1 cycle:
  - Ld_B=1, Sel_Sum=0.
  - Ofl_Sticky<=0, Iter<=0.
  - -> DONE.
- ADD, one cycle per addition:
  - Ld_B=1, Sel_Sum=1.
  - Ofl_Sticky<=Ofl_Sticky|Add_Ofl; Iter<=Iter+1; rem<=rem-1.
  - rem==1 -> DONE; else stay in ADD.
  - Exactly Reps consecutive Ld_B pulses per run.
- DONE, 1 cycle:
  - Done=1, Ld_B=0.
  - -> WAIT_REL.
- WAIT_REL:
  - Outputs idle; stay until Load==0 and Run==0 in the same cycle, then -> IDLE.
- All outputs are registered Moore outputs.
  - Ld_B/Sel_Sum are stable for the whole cycle in which they are asserted.
  - The datapath samples on the Ld_B strobe.
- Button edges outside IDLE are discarded; nothing is queued.
- Reps changes after acceptance have no effect on the running sequence.
- Iter and Ofl_Sticky hold their values after DONE until the next accepted Load or Run.
- Latency:
  - Run edge to first Ld_B: 1 cycle.
  - Run edge to Done: Reps+1 cycles (1 cycle when Reps=0).
  - Load edge to Done: 2 cycles.
- Reset mid-operation:
  - Sequence aborts immediately; no further Ld_B.
  - All outputs return to reset values.
  - Held buttons need release and re-press.
- Iter cannot wrap, since Iter <= Reps <= 2^CNT_W-1.

Test Plan:
- Reset, press and hold Load for 5 cycles -> exactly one Ld_B with Sel_Sum=0, Done 2 cycles after the edge, Busy 2 cycles; no second Ld_B until Load is released and pressed again.
- Reps=3, pulse Run, Add_Ofl=0 -> Ld_B high for 3 consecutive cycles with Sel_Sum=1, Iter=3, Done at cycle 4, Ofl_Sticky=0.
- Reps=5, Add_Ofl=1 only during the 2nd ADD cycle -> Ofl_Sticky=1 from cycle 3 and still 1 after Done; a subsequent Load edge clears it to 0.
- Reps=0, pulse Run -> no Ld_B, Done 1 cycle after the edge, Iter=0.
- Load and Run rise in the same cycle -> LOAD path only (single Ld_B, Sel_Sum=0); the Run edge is dropped.
- Reps=8, assert Reset after the 3rd Ld_B with Run still held -> outputs 0 immediately; after Reset deasserts, no Ld_B until Run goes low then high again.
